spi_master_v2_0: RTL and testbench
==================================

Name:
spi_master_v2_0

Overview:
- Single-clock SPI master front-end that selects one of three peripherals: W25Q16 flash, 74HC595 seven-segment shift-register chain, MPU6000.
- Per-bit serial data comes from the controller (MOSI_i); the block gates SCLK, drives active-low chip selects and counts bits against data_size_i.
- Read bits on MISO_i are forwarded to a downstream shift register over sr_wd_o/sr_we_o.
- Sits between the system controller and the board-level SPI pins.

Parameters:
- CNT_W, 13, width of data_size_i and of the internal bit counter.

Ports:
- clk_i  in  1  system clock; also the SPI bit rate (one bit per clk_i cycle)
- rst_i  in  1  reset, synchronous, active-high
- cs_flash_i  in  1  request flash transfer, active-high
- cs_shift_reg_i  in  1  request shift-register transfer, active-high
- cs_mpu_i  in  1  request MPU transfer, active-high
- data_size_i  in  13  transfer length in bits
- MOSI_i  in  1  next serial bit to send
- sr_out_en_i  in  1  shift-register output-enable request
- sr_we_i  in  1  shift-register write request
- master_mode_nrw  in  1  0 = read, 1 = write
- MISO_i  in  1  slave data in
- is_MISO_z_i  in  1  1 = MISO not driven, ignore it
- SCLK_o  out  1  serial clock
- RST_o  out  1  peripheral reset, active-high
- MOSI_o  out  1  serial data out
- cs_flash_o  out  1  flash chip select, active-low
- cs_shift_reg_o  out  1  shift-register chip select, active-low
- cs_mpu_o  out  1  MPU chip select, active-low
- sr_out_en_o  out  1  74HC595 output latch/enable
- sr_we_o  out  1  shift-register write strobe
- sr_wd_o  out  1  shift-register write data
- flash_we_o  out  1  flash write-mode indicator

Behaviour:
- Clock and reset: single clock clk_i; rst_i is synchronous and active-high.
- Reset values:
  - all cs_*_o = 1
  - SCLK_o = 0, MOSI_o = 0
  - sr_*_o = 0, flash_we_o = 0
  - RST_o = 1
  - FSM = IDLE, bit counter = 0
- RST_o is rst_i registered (1-cycle delay).
- Device select priority when several requests are high: flash > shift_reg > mpu. Exactly one cs_*_o is low while BUSY; all are high otherwise.
- FSM states:
  - IDLE:
    - On any cs_*_i high and data_size_i != 0: latch the selected device and data_size_i, clear the counter, go to BUSY. The selected cs_*_o goes low at the next clk_i edge.
    - data_size_i == 0: stay IDLE.
  - BUSY:
    - The counter increments each cycle.
    - When counter == latched size - 1, go to DONE on the next edge.
    - If the selected cs_*_i drops, go to IDLE immediately.
  - DONE:
    - cs_*_o returns high and SCLK stops.
    - Wait until all cs_*_i are low, then go to IDLE. This prevents retriggering while a request is held.
- SCLK_o = clk_i AND busy, where busy is a registered flag. SPI mode 0: idle low, the slave samples on the rising edge.
- MOSI_o = MOSI_i when busy and master_mode_nrw = 1; otherwise 0. Combinational pass-through, so the controller supplies each bit before the rising edge.
- Read capture: when busy, the selected device is flash or mpu, and is_MISO_z_i = 0:
  - sr_we_o = 1
  - sr_wd_o = MISO_i
  - This path is unaffected by master_mode_nrw.
- Shift-register path: when the selected device is shift_reg and busy:
  - sr_we_o = sr_we_i
  - sr_wd_o = MOSI_i
- Outside both cases above, sr_we_o = sr_we_i and sr_wd_o = 0.
- sr_out_en_o = sr_out_en_i registered (1-cycle delay); independent of the FSM.
- flash_we_o = 1 when busy, the selected device is flash, and master_mode_nrw = 1.
- rst_i mid-transfer: abort in the same edge; all outputs return to reset values.
- Latched size is held during BUSY; changes to data_size_i mid-transfer are ignored.

Decomposition:
- Package spi_master_pkg:
  - dev_e enum {DEV_NONE, DEV_FLASH, DEV_SR, DEV_MPU}
  - state_e enum {IDLE, BUSY, DONE}
  - constant CNT_W = 13
- One natural sub-module: spi_bit_counter. Loadable 13-bit up-counter with a terminal flag.

Test Plan:
- Reset: rst_i = 1 for 2 cycles -> cs_*_o = 1, SCLK_o = 0, RST_o = 1. Release -> RST_o = 0 one cycle later.
- Flash write: cs_i = 100, data_size_i = 32, nrw = 1, controller shifts 0x0B then 0xBB.
  - cs_flash_o low for exactly 32 cycles, with 32 SCLK_o pulses.
  - MOSI_o reproduces 0000_1011_1011_1011...
  - flash_we_o = 1 throughout; cs_flash_o high afterwards.
- Flash read: flash selected, is_MISO_z_i = 0, MISO_i = 1 for 32 cycles -> sr_we_o = 1 each cycle and the external 128-bit register receives 32 ones. With is_MISO_z_i = 1, sr_we_o = 0.
- Priority: cs_i = 111 -> only cs_flash_o low. cs_i = 011 -> only cs_shift_reg_o low.
- Seven-segment output: sr_out_en_i pulsed 1 cycle -> sr_out_en_o pulses 1 cycle, delayed 1 clk_i.
- Abort: rst_i asserted after 10 bits of a 32-bit transfer -> cs_*_o high and SCLK_o stops on that edge. data_size_i = 0 -> no chip select asserted.

Source files
------------

// File: rtl/spi_master_pkg.sv
// rtl/spi_master_pkg.sv - shared types and constants for the SPI master front-end
package spi_master_pkg;

  localparam int CNT_W = 13;

  typedef enum logic [1:0] {DEV_NONE, DEV_FLASH, DEV_SR, DEV_MPU} dev_e;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  // Fixed request priority: flash over shift register over MPU.
  function automatic dev_e pick_dev(input logic i_flash, input logic i_sr, input logic i_mpu);
    if (i_flash)    return DEV_FLASH;
    else if (i_sr)  return DEV_SR;
    else if (i_mpu) return DEV_MPU;
    else            return DEV_NONE;
  endfunction

endpackage

// File: rtl/spi_master_v2_0_bit_counter.sv
// rtl/spi_master_v2_0_bit_counter.sv - loadable up-counter with terminal-count flag
module spi_bit_counter #(
  parameter int W = 13
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  input  logic [W-1:0] i_last,
  output logic         o_term
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= i_load_val;
    else if (i_en)
      r_cnt <= r_cnt + 1'b1;
  end

  assign o_term = (r_cnt == i_last);

endmodule

// File: rtl/spi_master_v2_0.sv
// rtl/spi_master_v2_0.sv - SPI master front-end: device select, SCLK gating, bit counting
module spi_master_v2_0
  import spi_master_pkg::*;
#(
  parameter int CNT_W = 13
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cs_flash_i,
  input  logic             cs_shift_reg_i,
  input  logic             cs_mpu_i,
  input  logic [CNT_W-1:0] data_size_i,
  input  logic             MOSI_i,
  input  logic             sr_out_en_i,
  input  logic             sr_we_i,
  input  logic             master_mode_nrw,
  input  logic             MISO_i,
  input  logic             is_MISO_z_i,
  output logic             SCLK_o,
  output logic             RST_o,
  output logic             MOSI_o,
  output logic             cs_flash_o,
  output logic             cs_shift_reg_o,
  output logic             cs_mpu_o,
  output logic             sr_out_en_o,
  output logic             sr_we_o,
  output logic             sr_wd_o,
  output logic             flash_we_o
);

  state_e           r_state;
  dev_e             r_dev;
  logic [CNT_W-1:0] r_size;
  logic             r_rst;
  logic             r_sr_out_en;

  dev_e             w_req_dev;
  logic             w_start;
  logic             w_busy;
  logic             w_term;
  logic             w_sel_req;
  logic             w_any_req;
  logic [CNT_W-1:0] w_last;
  logic             w_sr_we;
  logic             w_sr_wd;

  assign w_req_dev = pick_dev(cs_flash_i, cs_shift_reg_i, cs_mpu_i);
  assign w_any_req = cs_flash_i | cs_shift_reg_i | cs_mpu_i;
  assign w_start   = (r_state == IDLE) && (w_req_dev != DEV_NONE) && (data_size_i != '0);
  assign w_busy    = (r_state == BUSY);
  assign w_last    = r_size - 1'b1;

  always_comb begin
    w_sel_req = 1'b0;
    case (r_dev)
      DEV_FLASH: w_sel_req = cs_flash_i;
      DEV_SR:    w_sel_req = cs_shift_reg_i;
      DEV_MPU:   w_sel_req = cs_mpu_i;
      default:   w_sel_req = 1'b0;
    endcase
  end

  spi_bit_counter #(.W(CNT_W)) u_bit_counter (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_load     (w_start),
    .i_load_val ('0),
    .i_en       (w_busy),
    .i_last     (w_last),
    .o_term     (w_term)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_dev   <= DEV_NONE;
      r_size  <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_start) begin
          r_dev   <= w_req_dev;
          r_size  <= data_size_i;
          r_state <= BUSY;
        end
        BUSY: if (!w_sel_req) begin
          r_dev   <= DEV_NONE;
          r_state <= IDLE;
        end else if (w_term) begin
          r_state <= DONE;
        end
        // Hold here until every request is released so a held request cannot retrigger.
        DONE: if (!w_any_req) begin
          r_dev   <= DEV_NONE;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    r_rst       <= rst_i;
    r_sr_out_en <= rst_i ? 1'b0 : sr_out_en_i;
  end

  always_comb begin
    w_sr_we = sr_we_i;
    w_sr_wd = 1'b0;
    if (w_busy && (r_dev == DEV_FLASH || r_dev == DEV_MPU) && !is_MISO_z_i) begin
      w_sr_we = 1'b1;
      w_sr_wd = MISO_i;
    end else if (w_busy && r_dev == DEV_SR) begin
      w_sr_we = sr_we_i;
      w_sr_wd = MOSI_i;
    end
  end

  assign SCLK_o         = clk_i & w_busy;
  assign RST_o          = r_rst;
  assign MOSI_o         = w_busy & master_mode_nrw & MOSI_i;
  assign cs_flash_o     = ~(w_busy && r_dev == DEV_FLASH);
  assign cs_shift_reg_o = ~(w_busy && r_dev == DEV_SR);
  assign cs_mpu_o       = ~(w_busy && r_dev == DEV_MPU);
  assign sr_out_en_o    = r_sr_out_en;
  assign sr_we_o        = ~rst_i & w_sr_we;
  assign sr_wd_o        = ~rst_i & w_sr_wd;
  assign flash_we_o     = w_busy && (r_dev == DEV_FLASH) && master_mode_nrw;

endmodule

// File: tb/tb_spi_master_v2_0.sv
// tb/tb_spi_master_v2_0.sv - scoreboard bench for spi_master_v2_0 with a transfer-level model
module tb_spi_master_v2_0;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cs_flash_i = 1'b0, cs_shift_reg_i = 1'b0, cs_mpu_i = 1'b0;
  logic [12:0] data_size_i = '0;
  logic        MOSI_i = 1'b0, sr_out_en_i = 1'b0, sr_we_i = 1'b0;
  logic        master_mode_nrw = 1'b0, MISO_i = 1'b0, is_MISO_z_i = 1'b1;
  logic        SCLK_o, RST_o, MOSI_o, cs_flash_o, cs_shift_reg_o, cs_mpu_o;
  logic        sr_out_en_o, sr_we_o, sr_wd_o, flash_we_o;

  spi_master_v2_0 dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cs_flash_i(cs_flash_i), .cs_shift_reg_i(cs_shift_reg_i), .cs_mpu_i(cs_mpu_i),
    .data_size_i(data_size_i), .MOSI_i(MOSI_i), .sr_out_en_i(sr_out_en_i),
    .sr_we_i(sr_we_i), .master_mode_nrw(master_mode_nrw), .MISO_i(MISO_i),
    .is_MISO_z_i(is_MISO_z_i), .SCLK_o(SCLK_o), .RST_o(RST_o), .MOSI_o(MOSI_o),
    .cs_flash_o(cs_flash_o), .cs_shift_reg_o(cs_shift_reg_o), .cs_mpu_o(cs_mpu_o),
    .sr_out_en_o(sr_out_en_o), .sr_we_o(sr_we_o), .sr_wd_o(sr_wd_o), .flash_we_o(flash_we_o)
  );

  always #5 clk_i = ~clk_i;

  // dev: 1 = flash, 2 = shift register, 3 = MPU
  typedef struct {
    int          dev;
    int          nbits;
    logic [63:0] mosi;
    logic [63:0] wd;
    int          we;
    int          fwe;
  } xfer_t;

  xfer_t        exp_q[$];
  int           total = 0;
  int           bad = 0;
  logic [127:0] ext_sr = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model one transfer of n bits, optionally cut short after `cut` bits by rst_i or by
  // dropping the request; then drive it one bit per cycle, each bit before its rising edge.
  task automatic do_xfer(input logic [2:0] cs, input int n, input logic nrw, input logic z,
                         input int cut, input bit use_rst, input logic [63:0] mosi,
                         input logic [63:0] miso, input logic [63:0] wei, input int hold);
    xfer_t e;
    int m;
    m = (cut > 0 && cut < n) ? cut : n;
    e.dev = cs[2] ? 1 : (cs[1] ? 2 : 3);
    e.nbits = m;
    e.mosi = '0; e.wd = '0; e.we = 0; e.fwe = 0;
    for (int i = 0; i < m; i++) begin
      e.mosi[i] = nrw & mosi[i];
      if (e.dev == 2) begin
        e.wd[i] = mosi[i];
        e.we += int'(wei[i]);
      end else if (!z) begin
        e.wd[i] = miso[i];
        e.we += 1;
      end else begin
        e.we += int'(wei[i]);
      end
      if (e.dev == 1 && nrw) e.fwe += 1;
    end
    exp_q.push_back(e);

    @(negedge clk_i);
    {cs_flash_i, cs_shift_reg_i, cs_mpu_i} = cs;
    data_size_i = 13'(n);
    master_mode_nrw = nrw;
    is_MISO_z_i = z;
    for (int i = 0; i < m; i++) begin
      if (i > 0) begin
        @(negedge clk_i);
        data_size_i = 13'($urandom_range(0, 8191));
      end
      MOSI_i = mosi[i]; MISO_i = miso[i]; sr_we_i = wei[i];
    end
    @(negedge clk_i);
    MOSI_i = 1'b0; MISO_i = 1'b0; sr_we_i = 1'b0;
    if (m < n) begin
      if (use_rst) rst_i = 1'b1;
      {cs_flash_i, cs_shift_reg_i, cs_mpu_i} = 3'b000;
      @(negedge clk_i);
      rst_i = 1'b0;
    end else begin
      repeat (hold + 1) @(negedge clk_i);
      {cs_flash_i, cs_shift_reg_i, cs_mpu_i} = 3'b000;
    end
    repeat (2) @(negedge clk_i);
  endtask

  // Monitor: assemble each chip-select window into a transfer record and score it.
  initial begin
    xfer_t cur, e;
    bit    in_x;
    bit    cs_bad;
    int    nlow, d, sclk_n;
    in_x = 0; cs_bad = 0; sclk_n = 0;
    cur.dev = 0; cur.nbits = 0; cur.mosi = '0; cur.wd = '0; cur.we = 0; cur.fwe = 0;
    forever begin
      @(posedge clk_i); #1;
      if (sr_we_o) ext_sr = {ext_sr[126:0], sr_wd_o};
      nlow = int'(!cs_flash_o) + int'(!cs_shift_reg_o) + int'(!cs_mpu_o);
      if (nlow != 0) begin
        d = !cs_flash_o ? 1 : (!cs_shift_reg_o ? 2 : 3);
        if (!in_x) begin
          in_x = 1; cs_bad = 0; sclk_n = 0;
          cur.dev = d; cur.nbits = 0; cur.mosi = '0; cur.wd = '0; cur.we = 0; cur.fwe = 0;
        end
        if (nlow != 1 || d != cur.dev) cs_bad = 1;
        if (cur.nbits < 64) begin
          cur.mosi[cur.nbits] = MOSI_o;
          cur.wd[cur.nbits] = sr_wd_o;
        end
        cur.nbits++;
        cur.we += int'(sr_we_o);
        cur.fwe += int'(flash_we_o);
        sclk_n += int'(SCLK_o);
      end else if (in_x) begin
        in_x = 0;
        if (exp_q.size() == 0) begin
          chk("unexpected_xfer", 64'(cur.nbits), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("cs_onehot", 64'(cs_bad), 64'd0);
          chk("xfer_dev", 64'(cur.dev), 64'(e.dev));
          chk("xfer_bits", 64'(cur.nbits), 64'(e.nbits));
          chk("sclk_pulses", 64'(sclk_n), 64'(e.nbits));
          chk("mosi_stream", cur.mosi, e.mosi);
          chk("sr_wd_stream", cur.wd, e.wd);
          chk("sr_we_count", 64'(cur.we), 64'(e.we));
          chk("flash_we_count", 64'(cur.fwe), 64'(e.fwe));
        end
      end
    end
  end

  initial begin
    logic [31:0] word;
    logic [63:0] pat, ones;
    logic [2:0]  rcs;
    int          n, cut;

    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_cs_flash", 64'(cs_flash_o), 64'd1);
    chk("rst_cs_sr", 64'(cs_shift_reg_o), 64'd1);
    chk("rst_cs_mpu", 64'(cs_mpu_o), 64'd1);
    chk("rst_sclk", 64'(SCLK_o), 64'd0);
    chk("rst_mosi", 64'(MOSI_o), 64'd0);
    chk("rst_flash_we", 64'(flash_we_o), 64'd0);
    chk("rst_sr_we", 64'(sr_we_o), 64'd0);
    chk("rst_rst_o", 64'(RST_o), 64'd1);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    chk("rst_o_release", 64'(RST_o), 64'd0);

    // Flash write of 0x0B then 0xBB..., MSB first
    word = 32'h0BBBBBBB;
    pat = '0;
    for (int i = 0; i < 32; i++) pat[i] = word[31-i];
    do_xfer(3'b100, 32, 1'b1, 1'b1, 0, 0, pat, 64'd0, 64'd0, 1);

    // Flash read of 32 ones into the external register
    @(negedge clk_i);
    ext_sr = '0;
    ones = 64'hFFFF_FFFF;
    do_xfer(3'b100, 32, 1'b0, 1'b0, 0, 0, 64'd0, ones, 64'd0, 0);
    chk("ext_sr_hi", ext_sr[127:64], 64'd0);
    chk("ext_sr_lo", ext_sr[63:0], 64'hFFFF_FFFF);
    do_xfer(3'b100, 16, 1'b0, 1'b1, 0, 0, 64'd0, ones, 64'd0, 0);

    do_xfer(3'b111, 8, 1'b1, 1'b1, 0, 0, 64'hA5, 64'd0, 64'd0, 2);
    do_xfer(3'b011, 8, 1'b1, 1'b1, 0, 0, 64'h3C, 64'd0, 64'hF0, 0);

    @(negedge clk_i);
    chk("sr_out_en_idle", 64'(sr_out_en_o), 64'd0);
    sr_out_en_i = 1'b1;
    @(posedge clk_i); #1;
    chk("sr_out_en_pulse", 64'(sr_out_en_o), 64'd1);
    @(negedge clk_i);
    sr_out_en_i = 1'b0;
    @(posedge clk_i); #1;
    chk("sr_out_en_end", 64'(sr_out_en_o), 64'd0);

    // Abort by reset after 10 of 32 bits
    do_xfer(3'b100, 32, 1'b1, 1'b1, 10, 1, {$urandom, $urandom}, 64'd0, 64'd0, 0);

    @(negedge clk_i);
    cs_flash_i = 1'b1;
    data_size_i = '0;
    repeat (4) begin
      @(posedge clk_i); #1;
      chk("size0_no_cs", 64'(cs_flash_o), 64'd1);
    end
    @(negedge clk_i);
    cs_flash_i = 1'b0;

    for (int t = 0; t < 30; t++) begin
      rcs = 3'($urandom_range(1, 7));
      n = $urandom_range(1, 64);
      cut = (n > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, n - 1) : 0;
      do_xfer(rcs, n, 1'($urandom), 1'($urandom), cut, bit'($urandom),
              {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
              $urandom_range(0, 3));
    end

    repeat (5) @(negedge clk_i);
    chk("pending_xfers", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
